pattern_gen: RTL and testbench

PATTERN_GEN -- requirements
Module: pattern_gen

---
 rtl/pattern_gen.sv | 113 +++++++++++
 tb/tb_pattern_gen.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_gen.sv
// Test-pattern colour source: per-request pixel colour for solid, checker, noise and
// scrolling-checker modes, with mode and scroll held constant across a frame.
module pattern_gen #(
    parameter int unsigned COLOR_W   = 8,
    parameter int unsigned CELL_LOG2 = 6,
    parameter int unsigned H_OFFSET  = 48,
    parameter int unsigned V_OFFSET  = 33,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter logic [30:0] SEED      = 31'd733
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req,
    input  logic [9:0]         col,
    input  logic [9:0]         row,
    input  logic               frame_start,
    input  logic [1:0]         mode,
    input  logic [COLOR_W-1:0] fg_color,
    output logic [COLOR_W-1:0] next_color,
    output logic               color_valid
);

    if (COLOR_W > 31 || COLOR_W == 0) begin : g_bad_color_w
        $error("pattern_gen: COLOR_W must be in 1..31");
    end
    if (CELL_LOG2 > 9) begin : g_bad_cell_log2
        $error("pattern_gen: CELL_LOG2 must be at most 9");
    end
    if (SEED == 31'd0) begin : g_bad_seed
        $error("pattern_gen: SEED must be non-zero");
    end

    typedef enum logic [1:0] {
        ModeSolid   = 2'b00,
        ModeChecker = 2'b01,
        ModeNoise   = 2'b10,
        ModeScroll  = 2'b11
    } mode_e;

    localparam logic [10:0] HStart   = 11'(H_OFFSET);
    localparam logic [10:0] HEnd     = 11'(H_OFFSET + H_ACTIVE);
    localparam logic [10:0] VStart   = 11'(V_OFFSET);
    localparam logic [10:0] VEnd     = 11'(V_OFFSET + V_ACTIVE);
    localparam logic [9:0]  HOff     = 10'(H_OFFSET);
    localparam logic [9:0]  VOff     = 10'(V_OFFSET);
    localparam logic [9:0]  CellMask = 10'(1) << CELL_LOG2;

    mode_e               mode_q, mode_d;
    logic [9:0]          scroll_q, scroll_d;
    logic [30:0]         lfsr_q, lfsr_d;
    logic [COLOR_W-1:0]  color_q, color_d;
    logic                valid_q, valid_d;

    logic                active;
    logic [9:0]          lcol, lrow, scol;
    logic                cell_plain, cell_scroll;
    logic [COLOR_W-1:0]  pix_color;

    // Coordinates wrap modulo 1024, matching the raw counters.
    always_comb begin
        lcol   = col - HOff;
        lrow   = row - VOff;
        scol   = lcol + scroll_q;
        active = ({1'b0, col} >= HStart) && ({1'b0, col} < HEnd) &&
                 ({1'b0, row} >= VStart) && ({1'b0, row} < VEnd);
        cell_plain  = (|(lcol & CellMask)) ^ (|(lrow & CellMask));
        cell_scroll = (|(scol & CellMask)) ^ (|(lrow & CellMask));
    end

    always_comb begin
        pix_color = '0;
        if (active) begin
            unique case (mode_q)
                ModeSolid:   pix_color = fg_color;
                ModeChecker: pix_color = cell_plain ? '0 : fg_color;
                ModeNoise:   pix_color = lfsr_q[COLOR_W-1:0];
                ModeScroll:  pix_color = cell_scroll ? '0 : fg_color;
                default:     pix_color = '0;
            endcase
        end
    end

    // Pixel uses the pre-update mode and scroll when frame_start coincides with req.
    always_comb begin
        lfsr_d   = (lfsr_q == 31'd0) ? SEED
                 : {lfsr_q[28:0], lfsr_q[30] ^ lfsr_q[28], lfsr_q[29] ^ lfsr_q[27]};
        mode_d   = frame_start ? mode_e'(mode) : mode_q;
        scroll_d = frame_start ? scroll_q + 10'd1 : scroll_q;
        color_d  = req ? pix_color : color_q;
        valid_d  = req;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q   <= ModeSolid;
            scroll_q <= '0;
            lfsr_q   <= SEED;
            color_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            scroll_q <= scroll_d;
            lfsr_q   <= lfsr_d;
            color_q  <= color_d;
            valid_q  <= valid_d;
        end
    end

    assign next_color  = color_q;
    assign color_valid = valid_q;

endmodule

// File: tb/tb_pattern_gen.sv
// Self-checking bench for pattern_gen against a frame-level reference model.
module tb_pattern_gen;

    logic       clk = 1'b0;
    logic       rst, req, frame_start;
    logic [9:0] col, row;
    logic [1:0] mode;
    logic [7:0] fg_color;
    logic [7:0] next_color;
    logic       color_valid;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    logic [30:0] m_lfsr;
    int          m_mode, m_scroll;
    logic [7:0]  exp_color;
    logic        exp_valid;

    pattern_gen dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .col        (col),
        .row        (row),
        .frame_start(frame_start),
        .mode       (mode),
        .fg_color   (fg_color),
        .next_color (next_color),
        .color_valid(color_valid)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_pix(int c, int r, int md, int scr,
                                           logic [30:0] lf, logic [7:0] fg);
        int lc, lr;
        bit dark;
        if (c < 48 || c >= 48 + 640 || r < 33 || r >= 33 + 480) return 8'h00;
        lc = c - 48;
        lr = r - 33;
        if (md == 3) lc = (lc + scr) % 1024;
        dark = ((lc / 64) % 2) != ((lr / 64) % 2);
        case (md)
            0:       return fg;
            2:       return lf[7:0];
            default: return dark ? 8'h00 : fg;
        endcase
    endfunction

    // Apply one cycle of inputs, advance the model across the edge, settle past it.
    task automatic drive(input logic r, input logic q, input int c, input int rw,
                         input logic f, input int m, input logic [7:0] g);
        rst = r; req = q; col = 10'(c); row = 10'(rw); frame_start = f;
        mode = 2'(m); fg_color = g;
        @(posedge clk);
        if (r) begin
            exp_color = 8'h00; exp_valid = 1'b0;
            m_lfsr = 31'd733; m_scroll = 0; m_mode = 0;
        end else begin
            if (q) exp_color = ref_pix(c, rw, m_mode, m_scroll, m_lfsr, g);
            exp_valid = q;
            m_lfsr = (m_lfsr == 31'd0) ? 31'd733
                   : {m_lfsr[28:0], m_lfsr[30] ^ m_lfsr[28], m_lfsr[29] ^ m_lfsr[27]};
            if (f) begin
                m_mode   = m;
                m_scroll = (m_scroll + 1) % 1024;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        drive(1, 1, 48, 33, 1, 1, 8'hFF);
        drive(1, 1, 48, 33, 1, 2, 8'hFF);
        n_cmp++;
        if (next_color !== 8'h00) begin
            n_fail++; $display("FAIL reset_color: got %h want 00", next_color);
        end
        n_cmp++;
        if (color_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_valid: got %b want 0", color_valid);
        end
        // Reset mid-frame leaves solid mode even with mode input non-zero
        drive(0, 1, 112, 33, 0, 1, 8'h5A);
        n_cmp++;
        if (next_color !== 8'h5A || color_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_solid: got %h/%b want 5a/1", next_color, color_valid);
        end
    endtask

    task automatic test_solid();
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        drive(0, 0, 0, 0, 1, 0, 8'h00);
        drive(0, 1, 48, 33, 0, 0, 8'hA4);
        n_cmp++;
        if (next_color !== 8'hA4 || color_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL solid_first: got %h/%b want a4/1", next_color, color_valid);
        end
    endtask

    task automatic test_checker();
        int cs [3] = '{48, 112, 112};
        int rs [3] = '{33, 33, 97};
        logic [7:0] want [3] = '{8'h3C, 8'h00, 8'h3C};
        drive(0, 0, 0, 0, 1, 1, 8'h3C);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, cs[i], rs[i], 0, 1, 8'h3C);
            n_cmp++;
            if (next_color !== want[i] || color_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL checker_%0d: got %h/%b want %h/1", i, next_color,
                         color_valid, want[i]);
            end
        end
        for (int i = 0; i < 40; i++) begin
            drive(0, 1, 48 + $urandom_range(0, 639), 33 + $urandom_range(0, 479), 0,
                  $urandom_range(0, 3), 8'($urandom));
            n_cmp++;
            if (next_color !== exp_color || color_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL checker_rand: got %h/%b want %h/%b", next_color,
                         color_valid, exp_color, exp_valid);
            end
        end
    endtask

    task automatic test_blanking();
        logic [7:0] held;
        for (int md = 0; md < 4; md++) begin
            drive(0, 0, 0, 0, 1, md, 8'h77);
            drive(0, 1, 10, 100, 0, md, 8'h77);
            n_cmp++;
            if (next_color !== 8'h00 || color_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL blank_m%0d: got %h/%b want 00/1", md, next_color, color_valid);
            end
        end
        drive(0, 0, 0, 0, 1, 0, 8'h77);
        drive(0, 1, 200, 200, 0, 0, 8'h77);
        held = exp_color;
        drive(0, 0, 300, 300, 0, 0, 8'h11);
        drive(0, 0, 10, 10, 0, 0, 8'h22);
        n_cmp++;
        if (next_color !== held || color_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL blank_hold: got %h/%b want %h/0", next_color, color_valid, held);
        end
    endtask

    task automatic test_noise();
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        drive(0, 1, 48, 33, 1, 2, 8'h99);
        n_cmp++;
        if (next_color !== 8'h99) begin
            n_fail++; $display("FAIL noise_old_mode: got %h want 99", next_color);
        end
        for (int i = 0; i < 60; i++) begin
            drive(0, ($urandom_range(0, 3) != 0), 48 + $urandom_range(0, 639),
                  33 + $urandom_range(0, 479), 0, 2, 8'($urandom));
            n_cmp++;
            if (next_color !== exp_color || color_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL noise_%0d: got %h/%b want %h/%b", i, next_color,
                         color_valid, exp_color, exp_valid);
            end
        end
    endtask

    task automatic test_scroll();
        drive(1, 0, 0, 0, 0, 0, 8'h00);
        for (int i = 0; i < 64; i++) drive(0, 0, 0, 0, 1, 3, 8'hE1);
        drive(0, 1, 48, 33, 0, 3, 8'hE1);
        n_cmp++;
        if (next_color !== 8'h00) begin
            n_fail++; $display("FAIL scroll_64: got %h want 00", next_color);
        end
        drive(0, 1, 112, 33, 0, 3, 8'hE1);
        n_cmp++;
        if (next_color !== 8'hE1) begin
            n_fail++; $display("FAIL scroll_64_b: got %h want e1", next_color);
        end
        for (int i = 0; i < 960; i++) drive(0, 0, 0, 0, 1, 3, 8'hE1);
        drive(0, 1, 48, 33, 0, 3, 8'hE1);
        n_cmp++;
        if (next_color !== 8'hE1) begin
            n_fail++; $display("FAIL scroll_wrap: got %h want e1", next_color);
        end
    endtask

    task automatic test_midframe();
        drive(0, 0, 0, 0, 1, 1, 8'h42);
        for (int i = 0; i < 3; i++) begin
            drive(0, 1, 112, 33, 0, 0, 8'h42);
            n_cmp++;
            if (next_color !== 8'h00) begin
                n_fail++; $display("FAIL midframe_%0d: got %h want 00", i, next_color);
            end
        end
        drive(0, 1, 112, 33, 1, 0, 8'h42);
        n_cmp++;
        if (next_color !== 8'h00) begin
            n_fail++; $display("FAIL midframe_coincide: got %h want 00", next_color);
        end
        drive(0, 1, 112, 33, 0, 0, 8'h42);
        n_cmp++;
        if (next_color !== 8'h42) begin
            n_fail++; $display("FAIL midframe_after: got %h want 42", next_color);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(($urandom_range(0, 49) == 0), $urandom_range(0, 1),
                  $urandom_range(0, 1023), $urandom_range(0, 1023),
                  ($urandom_range(0, 15) == 0), $urandom_range(0, 3), 8'($urandom));
            n_cmp++;
            if (next_color !== exp_color || color_valid !== exp_valid) begin
                n_fail++;
                $display("FAIL random_%0d: got %h/%b want %h/%b", i, next_color,
                         color_valid, exp_color, exp_valid);
            end
        end
    endtask

    initial begin
        m_lfsr = 31'd733; m_mode = 0; m_scroll = 0;
        exp_color = 8'h00; exp_valid = 1'b0;
        test_reset();
        test_solid();
        test_checker();
        test_blanking();
        test_noise();
        test_scroll();
        test_midframe();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
